// File: rtl/pll_reconfig_seq.sv
// PLL output-counter reconfiguration sequencer: programs one counter over the
// reconfig management bus, polls for completion, waits for lock, skips no-op requests.

module pll_shadow_entry (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       upd,
  input  logic       inv,
  input  logic [7:0] st_hi,
  input  logic [7:0] st_lo,
  input  logic       st_odd,
  input  logic [7:0] cmp_hi,
  input  logic [7:0] cmp_lo,
  input  logic       cmp_odd,
  output logic       hit
);
  logic       vld;
  logic [7:0] hi_q, lo_q;
  logic       odd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld   <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
      odd_q <= 1'b0;
    end else if (inv) begin
      vld <= 1'b0;
    end else if (upd) begin
      vld   <= 1'b1;
      hi_q  <= st_hi;
      lo_q  <= st_lo;
      odd_q <= st_odd;
    end
  end

  assign hit = vld && (hi_q == cmp_hi) && (lo_q == cmp_lo) && (odd_q == cmp_odd);
endmodule

module pll_reconfig_seq #(
  parameter int NUM_CLOCKS   = 3,
  parameter int CW           = 5,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [CW-1:0] req_chan,
  input  logic [7:0]    req_hi,
  input  logic [7:0]    req_lo,
  input  logic          req_odd,
  output logic          busy,
  output logic          done,
  output logic          err,
  input  logic          pll_locked,
  output logic [5:0]    mgmt_address,
  output logic          mgmt_read,
  output logic          mgmt_write,
  output logic [31:0]   mgmt_writedata,
  input  logic [31:0]   mgmt_readdata,
  input  logic          mgmt_waitrequest
);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WR_MODE   = 3'd1;
  localparam logic [2:0] WR_C      = 3'd2;
  localparam logic [2:0] WR_START  = 3'd3;
  localparam logic [2:0] POLL      = 3'd4;
  localparam logic [2:0] WAIT_LOCK = 3'd5;

  localparam logic [16:0] TMO  = 17'(LOCK_TIMEOUT);
  localparam logic [CW:0] NCLK = (CW+1)'(NUM_CLOCKS);

  typedef struct packed {
    logic [CW-1:0] chan;
    logic [7:0]    hi;
    logic [7:0]    lo;
    logic          odd;
  } req_t;

  logic [2:0]            state;
  req_t                  req_q;
  logic [16:0]           tmo_cnt;
  logic [16:0]           tmo_nxt;
  logic                  done_q, err_q;
  logic [NUM_CLOCKS-1:0] hit_vec, upd_vec, inv_vec;
  logic                  sel_hit, chan_ok;
  logic                  poll_ok, lock_ok, tmo_hit, tmo_fire;
  logic [4:0]            chan5;
  logic                  unused_rd;

  assign unused_rd = ^mgmt_readdata[31:1];
  assign chan5     = 5'(req_q.chan);
  assign chan_ok   = {1'b0, req_chan} < NCLK;
  assign tmo_nxt   = tmo_cnt + 17'd1;
  assign tmo_hit   = (tmo_nxt == TMO);
  assign poll_ok   = (state == POLL) && !mgmt_waitrequest && mgmt_readdata[0];
  assign lock_ok   = (state == WAIT_LOCK) && pll_locked;
  // Completion in the same cycle as the timeout wins.
  assign tmo_fire  = (((state == POLL) && !poll_ok) ||
                      ((state == WAIT_LOCK) && !pll_locked)) && tmo_hit;

  genvar g;
  generate
    for (g = 0; g < NUM_CLOCKS; g++) begin : g_shadow
      assign upd_vec[g] = lock_ok  && (req_q.chan == CW'(g));
      assign inv_vec[g] = tmo_fire && (req_q.chan == CW'(g));
      pll_shadow_entry u_entry (
        .clk     (clk),
        .rst_n   (rst_n),
        .upd     (upd_vec[g]),
        .inv     (inv_vec[g]),
        .st_hi   (req_q.hi),
        .st_lo   (req_q.lo),
        .st_odd  (req_q.odd),
        .cmp_hi  (req_hi),
        .cmp_lo  (req_lo),
        .cmp_odd (req_odd),
        .hit     (hit_vec[g])
      );
    end
  endgenerate

  always_comb begin
    sel_hit = 1'b0;
    for (int i = 0; i < NUM_CLOCKS; i++)
      if ((req_chan == CW'(i)) && hit_vec[i]) sel_hit = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      req_q   <= '0;
      tmo_cnt <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          if (!chan_ok)     err_q  <= 1'b1;
          else if (sel_hit) done_q <= 1'b1;
          else begin
            req_q <= '{chan: req_chan, hi: req_hi, lo: req_lo, odd: req_odd};
            state <= WR_MODE;
          end
        end
        WR_MODE:  if (!mgmt_waitrequest) state <= WR_C;
        WR_C:     if (!mgmt_waitrequest) state <= WR_START;
        WR_START: if (!mgmt_waitrequest) begin
          state   <= POLL;
          tmo_cnt <= '0;
        end
        POLL: begin
          if (poll_ok) begin
            state   <= WAIT_LOCK;
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_nxt;
            if (tmo_fire) begin
              err_q <= 1'b1;
              state <= IDLE;
            end
          end
        end
        WAIT_LOCK: begin
          if (lock_ok) begin
            done_q <= 1'b1;
            state  <= IDLE;
          end else begin
            tmo_cnt <= tmo_nxt;
            if (tmo_fire) begin
              err_q <= 1'b1;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus outputs decode straight from registered state, so they hold under stall.
  always_comb begin
    mgmt_read      = 1'b0;
    mgmt_write     = 1'b0;
    mgmt_address   = 6'd0;
    mgmt_writedata = 32'd0;
    case (state)
      WR_MODE: mgmt_write = 1'b1;
      WR_C: begin
        mgmt_write     = 1'b1;
        mgmt_address   = 6'd5;
        mgmt_writedata = {9'b0, chan5, req_q.odd, 1'b0, req_q.hi, req_q.lo};
      end
      WR_START: begin
        mgmt_write     = 1'b1;
        mgmt_address   = 6'd2;
        mgmt_writedata = 32'd1;
      end
      POLL: begin
        mgmt_read    = 1'b1;
        mgmt_address = 6'd1;
      end
      default: ;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = done_q;
  assign err       = err_q;
endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Directed bench for pll_reconfig_seq: full sequence, skip, bad channel, stall,
// timeout with shadow invalidation, and mid-sequence reset.

module tb_pll_reconfig_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [4:0]  req_chan;
  logic [7:0]  req_hi, req_lo;
  logic        req_odd;
  logic        busy, done, err;
  logic        pll_locked;
  logic [5:0]  mgmt_address;
  logic        mgmt_read, mgmt_write;
  logic [31:0] mgmt_writedata, mgmt_readdata;
  logic        mgmt_waitrequest;
  logic        status;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, acc_cyc = 0, done_cyc = 0, err_cyc = 0;
  int n_done = 0, n_err = 0, n_rd = 0, n_strobe = 0;
  logic [5:0]  wr_addr[$];
  logic [31:0] wr_data[$];

  pll_reconfig_seq #(.NUM_CLOCKS(3), .CW(5), .LOCK_TIMEOUT(20)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_chan(req_chan), .req_hi(req_hi), .req_lo(req_lo), .req_odd(req_odd),
    .busy(busy), .done(done), .err(err), .pll_locked(pll_locked),
    .mgmt_address(mgmt_address), .mgmt_read(mgmt_read), .mgmt_write(mgmt_write),
    .mgmt_writedata(mgmt_writedata), .mgmt_readdata(mgmt_readdata),
    .mgmt_waitrequest(mgmt_waitrequest)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  assign mgmt_readdata = {31'd0, status};

  // Bus/pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mgmt_write && !mgmt_waitrequest) begin
        wr_addr.push_back(mgmt_address);
        wr_data.push_back(mgmt_writedata);
      end
      if (mgmt_read && !mgmt_waitrequest) n_rd++;
      if (mgmt_read || mgmt_write) n_strobe++;
      if (done) begin n_done++; done_cyc = cyc; end
      if (err)  begin n_err++;  err_cyc  = cyc; end
      if (mgmt_read && mgmt_write) begin
        n_bad++; $display("FAIL rd_wr_overlap: read=1 write=1 at cycle %0d, required exclusive", cyc);
      end
      if (done && err) begin
        n_bad++; $display("FAIL done_err_overlap: both high at cycle %0d, required exclusive", cyc);
      end
    end
  end

  task automatic clear_log();
    wr_addr.delete(); wr_data.delete();
    n_done = 0; n_err = 0; n_rd = 0; n_strobe = 0;
  endtask

  // Called at posedge+1; returns at posedge+1 after acceptance edge.
  task automatic issue(input logic [4:0] ch, input logic [7:0] hi, input logic [7:0] lo, input logic od);
    req_valid = 1'b1; req_chan = ch; req_hi = hi; req_lo = lo; req_odd = od;
    @(negedge clk);
    acc_cyc = cyc;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++; $display("FAIL issue_ready: req_ready=%b, required 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_chan = 5'd0; req_hi = 8'hFF; req_lo = 8'hFF; req_odd = 1'b1;
  endtask

  task automatic wait_end(input int max, input string name);
    bit ok = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (done || err) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (!ok) begin
      n_bad++; $display("FAIL %s_timeout: no done/err within %0d cycles", name, max);
    end
  endtask

  task automatic check_full_seq(input string name, input logic [31:0] cdata, input int lat);
    n_cmp++;
    if (n_done !== 1 || n_err !== 0) begin
      n_bad++; $display("FAIL %s_pulses: done=%0d err=%0d, required 1/0", name, n_done, n_err);
    end
    n_cmp++;
    if (done_cyc - acc_cyc !== lat) begin
      n_bad++; $display("FAIL %s_latency: got %0d, required %0d", name, done_cyc - acc_cyc, lat);
    end
    n_cmp++;
    if (wr_addr.size() !== 3) begin
      n_bad++; $display("FAIL %s_nwrites: got %0d, required 3", name, wr_addr.size());
    end else begin
      n_cmp++;
      if (wr_addr[0] !== 6'd0 || wr_data[0] !== 32'd0 ||
          wr_addr[1] !== 6'd5 || wr_data[1] !== cdata ||
          wr_addr[2] !== 6'd2 || wr_data[2] !== 32'd1) begin
        n_bad++;
        $display("FAIL %s_writes: (%0d,%h) (%0d,%h) (%0d,%h), required (0,0) (5,%h) (2,1)",
                 name, wr_addr[0], wr_data[0], wr_addr[1], wr_data[1], wr_addr[2], wr_data[2], cdata);
      end
    end
    n_cmp++;
    if (n_rd !== 1) begin
      n_bad++; $display("FAIL %s_reads: got %0d, required 1", name, n_rd);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_chan = 0; req_hi = 0; req_lo = 0; req_odd = 0;
    pll_locked = 1'b1; mgmt_waitrequest = 1'b0; status = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({req_ready, busy, done, err, mgmt_read, mgmt_write} !== 6'b100000 ||
        mgmt_address !== 6'd0 || mgmt_writedata !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: rdy=%b busy=%b done=%b err=%b rd=%b wr=%b addr=%0d data=%h, required 1 0 0 0 0 0 0 0",
               req_ready, busy, done, err, mgmt_read, mgmt_write, mgmt_address, mgmt_writedata);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_full();
    clear_log();
    issue(5'd1, 8'd6, 8'd6, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || req_ready !== 1'b0) begin
      n_bad++; $display("FAIL full_busy: busy=%b ready=%b, required 1/0", busy, req_ready);
    end
    wait_end(50, "full");
    check_full_seq("full", 32'h0004_0606, 6);
  endtask

  task automatic test_skip();
    clear_log();
    issue(5'd1, 8'd6, 8'd6, 1'b0);
    wait_end(10, "skip");
    n_cmp++;
    if (n_done !== 1 || done_cyc - acc_cyc !== 1) begin
      n_bad++; $display("FAIL skip_done: count=%0d latency=%0d, required 1/1", n_done, done_cyc - acc_cyc);
    end
    n_cmp++;
    if (n_strobe !== 0) begin
      n_bad++; $display("FAIL skip_strobes: got %0d, required 0", n_strobe);
    end
  endtask

  task automatic test_bad_chan();
    clear_log();
    issue(5'd3, 8'd6, 8'd6, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || err !== 1'b1) begin
      n_bad++; $display("FAIL badchan_state: ready=%b busy=%b err=%b, required 1 0 1", req_ready, busy, err);
    end
    @(posedge clk); #1;
    repeat (3) @(posedge clk); #1;
    n_cmp++;
    if (n_err !== 1 || err_cyc - acc_cyc !== 1 || n_done !== 0 || n_strobe !== 0) begin
      n_bad++; $display("FAIL badchan_result: err=%0d lat=%0d done=%0d strobes=%0d, required 1 1 0 0",
                        n_err, err_cyc - acc_cyc, n_done, n_strobe);
    end
  endtask

  task automatic test_stall();
    bit stable = 1;
    clear_log();
    issue(5'd2, 8'd3, 8'd2, 1'b1);
    @(posedge clk); #1;
    mgmt_waitrequest = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (mgmt_write !== 1'b1 || mgmt_read !== 1'b0 || mgmt_address !== 6'd5 ||
          mgmt_writedata !== 32'h000A_0302) stable = 0;
      @(posedge clk);
    end
    #1 mgmt_waitrequest = 1'b0;
    n_cmp++;
    if (!stable) begin
      n_bad++; $display("FAIL stall_hold: addr=%0d data=%h wr=%b, required 5 000a0302 1 throughout",
                        mgmt_address, mgmt_writedata, mgmt_write);
    end
    wait_end(50, "stall");
    check_full_seq("stall", 32'h000A_0302, 16);
  endtask

  task automatic test_timeout();
    clear_log();
    issue(5'd0, 8'd4, 8'd4, 1'b0);
    wait_end(50, "tmo_prime");
    check_full_seq("tmo_prime", 32'h0000_0404, 6);
    clear_log();
    status = 1'b0;
    issue(5'd0, 8'd5, 8'd5, 1'b0);
    wait_end(100, "tmo");
    n_cmp++;
    if (n_err !== 1 || n_done !== 0 || n_rd !== 20 || err_cyc - acc_cyc !== 24) begin
      n_bad++; $display("FAIL tmo_err: err=%0d done=%0d reads=%0d lat=%0d, required 1 0 20 24",
                        n_err, n_done, n_rd, err_cyc - acc_cyc);
    end
    @(negedge clk);
    n_cmp++;
    if (mgmt_read !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL tmo_idle: read=%b busy=%b, required 0/0", mgmt_read, busy);
    end
    @(posedge clk); #1;
    status = 1'b1;
    clear_log();
    issue(5'd0, 8'd4, 8'd4, 1'b0);
    wait_end(50, "tmo_inval");
    check_full_seq("tmo_inval", 32'h0000_0404, 6);
    clear_log();
    issue(5'd0, 8'd5, 8'd5, 1'b0);
    wait_end(50, "tmo_retry");
    check_full_seq("tmo_retry", 32'h0000_0505, 6);
  endtask

  task automatic test_reset_mid();
    bit quiet = 1;
    clear_log();
    status = 1'b0;
    issue(5'd2, 8'd9, 8'd9, 1'b0);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({req_ready, busy, done, err, mgmt_read, mgmt_write} !== 6'b100000 || mgmt_address !== 6'd0) begin
      n_bad++; $display("FAIL midrst_async: rdy=%b busy=%b done=%b err=%b rd=%b wr=%b addr=%0d, required 1 0 0 0 0 0 0",
                        req_ready, busy, done, err, mgmt_read, mgmt_write, mgmt_address);
    end
    repeat (3) begin
      @(negedge clk);
      if (done || err) quiet = 0;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done || err) quiet = 0;
    end
    @(posedge clk); #1;
    n_cmp++;
    if (!quiet || n_done !== 0 || n_err !== 0) begin
      n_bad++; $display("FAIL midrst_pulse: done=%0d err=%0d, required no pulse", n_done, n_err);
    end
    status = 1'b1;
    clear_log();
    issue(5'd1, 8'd6, 8'd6, 1'b0);
    wait_end(50, "midrst_after");
    check_full_seq("midrst_after", 32'h0004_0606, 6);
  endtask

  initial begin
    test_reset();
    test_full();
    test_skip();
    test_bad_chan();
    test_stall();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pll_reconfig_seq.md
PLL_RECONFIG_SEQ -- requirements
Module: pll_reconfig_seq

Interface
REQ-001 SHALL have parameter NUM_CLOCKS, default 3, the number of PLL output counters managed (legal 1..18).
REQ-002 SHALL have parameter CW, default 5, the channel-select width (NUM_CLOCKS <= 2**CW).
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 65535, the maximum wait in clk cycles for completion and for lock.
REQ-004 SHALL use one clock and an asynchronous, active-low reset; all state SHALL be reset asynchronously when rst_n is low.
REQ-005 SHALL provide ports (name, direction, width, meaning):
- clk  in  1  single clock
- rst_n  in  1  async active-low reset
- req_valid  in  1  reconfiguration request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_chan  in  CW  output counter index
- req_hi  in  8  counter high count
- req_lo  in  8  counter low count
- req_odd  in  1  odd-division duty correction
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse on success
- err  out  1  one-cycle pulse on failure
- pll_locked  in  1  PLL lock indicator (pre-synchronised)
- mgmt_address  out  6  reconfig register address
- mgmt_read  out  1  read strobe
- mgmt_write  out  1  write strobe
- mgmt_writedata  out  32  write data
- mgmt_readdata  in  32  read data
- mgmt_waitrequest  in  1  stall; strobes and address/data SHALL hold while high

Function
REQ-006 SHALL implement states IDLE, WR_MODE, WR_C, WR_START, POLL, WAIT_LOCK.
REQ-007 req_ready SHALL be 1 only in IDLE; busy SHALL be 1 in every state except IDLE.
REQ-008 On acceptance in IDLE, channel, hi, lo and odd SHALL be latched; the later req_* values SHALL be ignored until return to IDLE.
REQ-009 If req_chan >= NUM_CLOCKS, the block SHALL pulse err on the cycle after acceptance, issue no bus access, and stay in IDLE.
REQ-010 A per-channel shadow (hi, lo, odd, valid bit) SHALL be kept; if the request matches a valid shadow entry, the block SHALL pulse done on the cycle after acceptance with no bus access (skip).
REQ-011 WR_MODE SHALL write address 0, data 0 (waitrequest mode), then go to WR_C.
REQ-012 WR_C SHALL write address 5, data = {9'b0, chan[4:0] at [22:18], odd at [17], 1'b0 bypass at [16], hi at [15:8], lo at [7:0]}, then go to WR_START.
REQ-013 WR_START SHALL write address 2, data 1, then go to POLL.
REQ-014 A write or read SHALL complete on the first cycle its strobe is high with mgmt_waitrequest low; mgmt_read and mgmt_write SHALL never be high together.
REQ-015 POLL SHALL read address 1 repeatedly; when a completed read returns bit0 = 1, the block SHALL go to WAIT_LOCK.
REQ-016 WAIT_LOCK SHALL complete on the first cycle pll_locked = 1: it SHALL pulse done, update the shadow entry (valid = 1), and go to IDLE.
REQ-017 A 17-bit timeout counter SHALL clear on entry to POLL and on entry to WAIT_LOCK, and SHALL increment each cycle in those states; at count == LOCK_TIMEOUT the block SHALL pulse err, clear that channel's shadow valid bit, drop all strobes, and go to IDLE.
REQ-018 Timeout SHALL NOT apply in WR_* states; a write stalled by waitrequest SHALL wait indefinitely.
REQ-019 done and err SHALL never be asserted in the same cycle; each SHALL be high for exactly one cycle per request.
REQ-020 Minimum latency from acceptance to done, with zero waitrequest, status ready at the first read, and lock already high, SHALL be 6 cycles (3 writes, 1 read, 1 lock check, 1 output register).

Reset
REQ-021 While rst_n is low: state = IDLE, req_ready = 1, busy = 0, done = 0, err = 0, mgmt_read = 0, mgmt_write = 0, mgmt_address = 0, mgmt_writedata = 0, all shadow valid bits = 0, timeout counter = 0.
REQ-022 Reset asserted mid-sequence SHALL abort immediately with no done or err pulse; after reset is released, the first request for any channel SHALL perform the full bus sequence.

Verification
REQ-023 Request chan = 1, hi = 6, lo = 6, odd = 0, no stalls, status bit0 = 1, locked = 1 -> writes (0,0), (5,0x00040606), (2,1), then read addr 1; done exactly 6 cycles after acceptance.
REQ-024 Repeat the same request -> done one cycle after acceptance, with zero mgmt strobes.
REQ-025 Request chan = 3 with NUM_CLOCKS = 3 -> err one cycle after acceptance, no bus activity, req_ready stays high.
REQ-026 Hold waitrequest high for 10 cycles during WR_C -> address and data held stable, single write completes, sequence finishes with done.
REQ-027 LOCK_TIMEOUT = 20, status bit0 stays 0 -> err after 20 POLL cycles; the same request is then issued again -> full bus sequence (shadow invalidated).
REQ-028 Assert rst_n low during POLL -> all outputs reach reset values asynchronously, no done or err pulse; after release, a new request is accepted.
